// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame length
// and the baud divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int FRAME_BITS = 8;

   function automatic int calc_bit_cyc(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int calc_half_cyc(input int bit_cyc);
      return bit_cyc / 2;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RST_VAL so the output idles at a known level.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle
// rx_valid / frame_err strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       en,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int BIT_CYC  = calc_bit_cyc(CLK_FREQ, BAUD);
   localparam int HALF_CYC = calc_half_cyc(BIT_CYC);
   localparam int CNT_W    = $clog2(BIT_CYC);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(FRAME_BITS - 1);

   uart_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       rx_data_nxt;
   logic             rx_valid_nxt, frame_err_nxt;
   logic             rxs, rxs_p1;
   logic [1:0]       prime;
   logic             fall;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (rxd),
      .q     (rxs)
   );

   // The synchronizer flops come out of reset at 1 whatever the line level is;
   // edges are ignored until real line samples have reached rxs_p1.
   assign fall = (prime == 2'd3) && rxs_p1 && !rxs;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rxs_p1    <= 1'b1;
         prime     <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
         rxs_p1    <= rxs;
         if (prime != 2'd3) prime <= prime + 2'd1;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt + CNT_W'(1);
      bit_cnt_nxt   = bit_cnt;
      shreg_nxt     = shreg;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      if (!en) begin
         state_nxt   = IDLE;
         cnt_nxt     = '0;
         bit_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nxt = '0;
               if (fall) state_nxt = START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt_nxt     = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = rxs ? IDLE : DATA;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt     = '0;
                  shreg_nxt   = {rxs, shreg[7:1]};
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) state_nxt = STOP;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt_nxt = '0;
                  if (rxs) begin
                     rx_data_nxt  = shreg;
                     rx_valid_nxt = 1'b1;
                  end else begin
                     frame_err_nxt = 1'b1;
                  end
                  // A start edge coinciding with the stop sample opens the next frame.
                  state_nxt = fall ? START : IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, received bytes and
// strobes compared against expectations queued by the frame driver.
module tb_uart_rx;

   localparam int CLK_FREQ = 5_000_000;
   localparam int BAUD     = 115200;
   localparam int BIT_CYC  = CLK_FREQ / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int LAT      = 3 + HALF_CYC + 9 * BIT_CYC;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       en;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (en),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: what the line should yield, queued by the driver
   logic [7:0] exp_q[$];
   int         exp_start[$];
   int         exp_ferr = 0;

   // Observations
   logic [7:0] got_q[$];
   int         got_cyc[$];
   int         ferr_cnt = 0;
   int         overlap_cnt = 0;
   int         double_cnt = 0;
   int         data_chg_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (rx_valid) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
         end
         if (frame_err) ferr_cnt++;
         if (rx_valid && frame_err) overlap_cnt++;
         if (rx_valid && prev_valid) double_cnt++;
         if (rx_data !== prev_data && !rx_valid) data_chg_cnt++;
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
   end

   task automatic idle_bits(input int bits);
      rxd = 1'b1;
      repeat (bits * BIT_CYC) @(negedge sys_clk);
   endtask

   // Drives one frame starting at the current negedge; rst_bit >= 0 pulses
   // reset in the middle of that data bit and the frame is not expected.
   task automatic send(input logic [7:0] d, input logic stop_bit, input bit expect_it,
                       input int rst_bit);
      int t0;
      rxd = 1'b0;
      t0  = cyc;
      repeat (BIT_CYC) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         if (i == rst_bit) begin
            repeat (BIT_CYC / 2) @(negedge sys_clk);
            sys_rst_n = 1'b0;
            @(negedge sys_clk);
            chk("rst_mid_rx_data", rx_data, 8'h00);
            chk("rst_mid_rx_valid", rx_valid, 1'b0);
            repeat (2) @(negedge sys_clk);
            sys_rst_n = 1'b1;
            repeat (BIT_CYC - BIT_CYC / 2 - 3) @(negedge sys_clk);
         end else begin
            repeat (BIT_CYC) @(negedge sys_clk);
         end
      end
      rxd = stop_bit;
      repeat (BIT_CYC) @(negedge sys_clk);
      rxd = 1'b1;
      if (expect_it && rst_bit < 0) begin
         if (stop_bit) begin
            exp_q.push_back(d);
            exp_start.push_back(t0);
         end else begin
            exp_ferr++;
         end
      end
   endtask

   task automatic check_results(input string tag);
      int n;
      int lat;
      repeat (2 * BIT_CYC) @(negedge sys_clk);
      chk({tag, "_n_valid"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, got_q[i], exp_q[i]);
         lat = got_cyc[i] - exp_start[i];
         chk({tag, "_latency_in_window"}, (lat >= LAT - 2 && lat <= LAT + 2), 1'b1);
      end
      chk({tag, "_n_frame_err"}, ferr_cnt, exp_ferr);
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
      exp_start.delete();
      ferr_cnt = 0;
      exp_ferr = 0;
   endtask

   initial begin
      logic [7:0] rb;
      logic       rstop;
      bit         prev_bad;
      sys_rst_n = 1'b0;
      en        = 1'b0;
      rxd       = 1'b1;
      repeat (5) @(negedge sys_clk);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      sys_rst_n = 1'b1;
      en        = 1'b1;
      idle_bits(2);

      send(8'h55, 1'b1, 1'b1, -1);
      check_results("frame_55");

      send(8'hA5, 1'b1, 1'b1, -1);
      send(8'h3C, 1'b1, 1'b1, -1);
      check_results("back_to_back");

      rxd = 1'b0;
      repeat (10) @(negedge sys_clk);
      idle_bits(1);
      send(8'h5A, 1'b1, 1'b1, -1);
      check_results("glitch_then_5a");

      send(8'hFF, 1'b0, 1'b1, -1);
      check_results("bad_stop");
      chk("bad_stop_data_kept", rx_data, 8'h5A);

      idle_bits(1);
      send(8'h81, 1'b1, 1'b0, 4);
      idle_bits(2);
      send(8'h81, 1'b1, 1'b1, -1);
      check_results("reset_mid_frame");

      en = 1'b0;
      idle_bits(1);
      send(8'h42, 1'b1, 1'b0, -1);
      en = 1'b1;
      idle_bits(1);
      send(8'h42, 1'b1, 1'b1, -1);
      check_results("en_gate");

      rxd = 1'b0;
      repeat (20 * BIT_CYC) @(negedge sys_clk);
      exp_ferr = 1;
      idle_bits(2);
      check_results("line_stuck_low");
      chk("stuck_low_data_kept", rx_data, 8'h42);

      prev_bad = 1'b0;
      for (int k = 0; k < 30; k++) begin
         rb    = 8'($urandom);
         rstop = ($urandom_range(0, 5) != 0);
         idle_bits(prev_bad ? $urandom_range(1, 2) : $urandom_range(0, 2));
         send(rb, rstop, 1'b1, -1);
         prev_bad = !rstop;
      end
      idle_bits(1);
      check_results("random");

      chk("valid_and_ferr_overlap", overlap_cnt, 0);
      chk("valid_longer_than_1", double_cnt, 0);
      chk("rx_data_changed_without_valid", data_chg_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
